// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory-stage controller.
//               mem_state_t - controller FSM states (IDLE, ACCESS)
//               memwb_t     - contents of the MEM->WB pipeline register
//               hold_t      - in-flight memory access latched while waiting
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned REG_ADDR_W    = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // MEM->WB register payload. An all-zero value is a bubble.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] read_data;
    logic [DEFAULT_WIDTH-1:0] alu_result;
    logic [DEFAULT_WIDTH-1:0] pc_plus4;
    logic [REG_ADDR_W-1:0]    rd;
    logic                     reg_write;
    logic                     result_src;
    logic                     wd3_src;
  } memwb_t;

  // Snapshot of the M-stage instruction taken when a request has to wait.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] addr;
    logic [DEFAULT_WIDTH-1:0] wdata;
    logic [DEFAULT_WIDTH-1:0] pc_plus4;
    logic [REG_ADDR_W-1:0]    rd;
    logic                     reg_write;
    logic                     result_src;
    logic                     wd3_src;
    logic                     we;
  } hold_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_ctrl_memwb.sv
// ============================================================================
// Module      : pipeline_MEMtoWB
// Description : MEM->WB pipeline register. Loads wb_in every cycle, or an
//               all-zero bubble when bubble=1. Synchronous active-low reset.
// Ports       : clk, rst_n      - clock / synchronous active-low reset
//               bubble          - load zeros instead of wb_in
//               wb_in / wb_out  - register input / registered W-stage value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_MEMtoWB
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble,
  input  memwb_t wb_in,
  output memwb_t wb_out
);

  memwb_t wb_q;
  memwb_t wb_d;

  always_comb begin
    wb_d = wb_in;
    if (bubble) begin
      wb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_out = wb_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage controller. Issues load/store requests over a
//               req/ready handshake, holds a waiting access stable, stalls the
//               front of the pipeline while memory is busy and registers the
//               completed result into the MEM->WB register.
// Ports       : clk, rst_n                 - clock / sync active-low reset
//               *M inputs                   - EXE->MEM register contents
//               dmem_req/we/addr/wdata      - memory request
//               dmem_ready/rdata            - memory completion / load data
//               stall_mem                   - freeze upstream pipeline
//               *W outputs                  - MEM->WB register contents
//               timeout_err                 - sticky access-timeout flag
// Options     : MEM_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES ACCESS
//               cycles without dmem_ready; otherwise wait indefinitely and
//               tie timeout_err to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [WIDTH-1:0] PCPlus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             ResultSrcM,
  input  logic             WDMEM,
  input  logic             WD3SrcM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ready,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             stall_mem,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic             WD3SrcW,
  output logic             timeout_err
);

  mem_state_t state_q, state_d;
  hold_t      hold_q, hold_d;
  memwb_t     wb_in, wb_out;
  logic       wb_bubble;
  logic       mem_op;
  logic       is_load_m;
  logic       timeout_hit;

  // Store wins when both load and store controls are set.
  assign mem_op    = ResultSrcM | WDMEM;
  assign is_load_m = ResultSrcM & ~WDMEM;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    wb_in      = '0;
    wb_bubble  = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst_n so no request escapes while held in reset.
        dmem_req   = mem_op & rst_n;
        dmem_we    = WDMEM;
        dmem_addr  = ALUResultM;
        dmem_wdata = WriteDataM;

        wb_in.read_data  = is_load_m ? dmem_rdata : '0;
        wb_in.alu_result = ALUResultM;
        wb_in.pc_plus4   = PCPlus4M;
        wb_in.rd         = RdM;
        wb_in.reg_write  = RegWriteM & ~WDMEM;
        wb_in.result_src = ResultSrcM;
        wb_in.wd3_src    = WD3SrcM;

        if (mem_op && !dmem_ready) begin
          hold_d.addr       = ALUResultM;
          hold_d.wdata      = WriteDataM;
          hold_d.pc_plus4   = PCPlus4M;
          hold_d.rd         = RdM;
          hold_d.reg_write  = RegWriteM & ~WDMEM;
          hold_d.result_src = ResultSrcM;
          hold_d.wd3_src    = WD3SrcM;
          hold_d.we         = WDMEM;
          wb_bubble         = 1'b1;
          state_d           = ACCESS;
        end
      end

      ACCESS: begin
        dmem_req   = 1'b1;
        dmem_we    = hold_q.we;
        dmem_addr  = hold_q.addr;
        dmem_wdata = hold_q.wdata;

        wb_in.read_data  = hold_q.we ? '0 : dmem_rdata;
        wb_in.alu_result = hold_q.addr;
        wb_in.pc_plus4   = hold_q.pc_plus4;
        wb_in.rd         = hold_q.rd;
        wb_in.reg_write  = hold_q.reg_write;
        wb_in.result_src = hold_q.result_src;
        wb_in.wd3_src    = hold_q.wd3_src;

        if (dmem_ready) begin
          state_d = IDLE;
        end else begin
          wb_bubble = 1'b1;
          if (timeout_hit) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Upstream freezes whenever a live request has not completed this cycle,
  // including the IDLE cycle that first issues a waiting request.
  assign stall_mem = dmem_req & ~dmem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] tmo_cnt_inc;

  // tmo_cnt_q holds the number of earlier ACCESS cycles, so the increment
  // is the ordinal of the current ACCESS cycle.
  assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);
  assign timeout_hit = (state_q == ACCESS) && !dmem_ready &&
                       (tmo_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_cnt_d     = '0;
    timeout_err_d = timeout_err_q;
    if (state_q == ACCESS && !dmem_ready) begin
      if (timeout_hit) begin
        timeout_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  pipeline_MEMtoWB u_memwb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (wb_bubble),
    .wb_in  (wb_in),
    .wb_out (wb_out)
  );

  assign ReadDataW  = wb_out.read_data;
  assign ALUResultW = wb_out.alu_result;
  assign PCPlus4W   = wb_out.pc_plus4;
  assign RdW        = wb_out.rd;
  assign RegWriteW  = wb_out.reg_write;
  assign ResultSrcW = wb_out.result_src;
  assign WD3SrcW    = wb_out.wd3_src;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Directed self-checking bench for mem_stage_ctrl. Inputs change
//               1 time unit after the rising edge; outputs are checked in the
//               same window, before the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, WDMEM, WD3SrcM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, ResultSrcW, WD3SrcW;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .WDMEM      (WDMEM),
    .WD3SrcM    (WD3SrcM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .stall_mem  (stall_mem),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .WD3SrcW    (WD3SrcW),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic rs,
                       input logic wdm, input logic wd3);
    ALUResultM = alu;
    WriteDataM = wd;
    PCPlus4M   = pc4;
    RdM        = rd;
    RegWriteM  = rw;
    ResultSrcM = rs;
    WDMEM      = wdm;
    WD3SrcM    = wd3;
  endtask

  task automatic nop();
    set_m(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_ReadDataW"},  ReadDataW,  32'h0);
    check({tag, "_ALUResultW"}, ALUResultW, 32'h0);
    check({tag, "_PCPlus4W"},   PCPlus4W,   32'h0);
    check({tag, "_RdW"},        {27'h0, RdW}, 32'h0);
    check({tag, "_RegWriteW"},  {31'h0, RegWriteW}, 32'h0);
    check({tag, "_ResultSrcW"}, {31'h0, ResultSrcW}, 32'h0);
    check({tag, "_WD3SrcW"},    {31'h0, WD3SrcW}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset: a load on M must not issue a request
    rst_n      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    set_m(32'h40, 32'h0, 32'h44, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_req",   {31'h0, dmem_req},  32'h0);
    check("rst_stall", {31'h0, stall_mem}, 32'h0);
    check("rst_tmo",   {31'h0, timeout_err}, 32'h0);
    check_w_zero("rst");
    nop();
    rst_n = 1'b1;

    // ---------------- ALU op passes through in one cycle
    set_m(32'h10, 32'h0, 32'h104, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("alu_req",   {31'h0, dmem_req},  32'h0);
    check("alu_stall", {31'h0, stall_mem}, 32'h0);
    tick();
    check("alu_ALUResultW", ALUResultW, 32'h10);
    check("alu_RdW",        {27'h0, RdW}, 32'd5);
    check("alu_RegWriteW",  {31'h0, RegWriteW}, 32'h1);
    check("alu_PCPlus4W",   PCPlus4W, 32'h104);
    check("alu_WD3SrcW",    {31'h0, WD3SrcW}, 32'h1);
    check("alu_ReadDataW",  ReadDataW, 32'h0);

    // ---------------- zero-wait load
    set_m(32'h40, 32'h0, 32'h108, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("zl_req",   {31'h0, dmem_req},  32'h1);
    check("zl_we",    {31'h0, dmem_we},   32'h0);
    check("zl_addr",  dmem_addr, 32'h40);
    check("zl_stall", {31'h0, stall_mem}, 32'h0);
    tick();
    check("zl_ReadDataW",  ReadDataW, 32'hDEADBEEF);
    check("zl_ResultSrcW", {31'h0, ResultSrcW}, 32'h1);
    check("zl_RegWriteW",  {31'h0, RegWriteW}, 32'h1);
    check("zl_RdW",        {27'h0, RdW}, 32'd7);

    // ---------------- ready with no request is ignored
    nop();
    ALUResultM = 32'h55;
    dmem_rdata = 32'h12345678;
    #1;
    check("ign_req", {31'h0, dmem_req}, 32'h0);
    tick();
    check("ign_ReadDataW",  ReadDataW, 32'h0);
    check("ign_ALUResultW", ALUResultW, 32'h55);
    dmem_ready = 1'b0;

    // ---------------- store with 3 wait cycles, M switched to junk meanwhile
    stall_cycles = 0;
    set_m(32'h80, 32'h1234, 32'h10C, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        dmem_ready = 1'b1;
        #1;
      end
      check($sformatf("st_req_%0d", i),   {31'h0, dmem_req}, 32'h1);
      check($sformatf("st_we_%0d", i),    {31'h0, dmem_we},  32'h1);
      check($sformatf("st_addr_%0d", i),  dmem_addr,  32'h80);
      check($sformatf("st_wdata_%0d", i), dmem_wdata, 32'h1234);
      check($sformatf("st_regwr_%0d", i), {31'h0, RegWriteW}, 32'h0);
      if (stall_mem === 1'b1) stall_cycles++;
      tick();
      if (i == 0) set_m(32'h999, 32'h777, 32'h200, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      if (i < 2) check($sformatf("st_bubble_alu_%0d", i), ALUResultW, 32'h0);
    end
    check("st_stall_cycles", stall_cycles, 32'd3);
    check("st_ALUResultW", ALUResultW, 32'h80);
    check("st_RdW",        {27'h0, RdW}, 32'd9);
    check("st_RegWriteW",  {31'h0, RegWriteW}, 32'h0);
    check("st_ReadDataW",  ReadDataW, 32'h0);

    // ---------------- back-to-back: one-wait load right after the store
    dmem_ready = 1'b0;
    set_m(32'h44, 32'h0, 32'h110, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("b2b_req",   {31'h0, dmem_req},  32'h1);
    check("b2b_stall", {31'h0, stall_mem}, 32'h1);
    tick();
    nop();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    check("b2b_addr",  dmem_addr, 32'h44);
    check("b2b_stall_done", {31'h0, stall_mem}, 32'h0);
    tick();
    check("b2b_ReadDataW", ReadDataW, 32'hCAFEF00D);
    check("b2b_RdW",       {27'h0, RdW}, 32'd11);
    check("b2b_RegWriteW", {31'h0, RegWriteW}, 32'h1);
    check("b2b_PCPlus4W",  PCPlus4W, 32'h110);
    dmem_ready = 1'b0;

    // ---------------- reset during the 2nd ACCESS cycle of a load
    set_m(32'h48, 32'h0, 32'h114, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    #1;
    check("rmid_req",   {31'h0, dmem_req},  32'h0);
    check("rmid_stall", {31'h0, stall_mem}, 32'h0);
    check_w_zero("rmid");
    rst_n = 1'b1;
    nop();
    #1;
    check("rmid_idle_req", {31'h0, dmem_req}, 32'h0);
    check("tmo_default", {31'h0, timeout_err}, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // ---------------- timeout: ready never arrives
    set_m(32'h60, 32'h0, 32'h118, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("tmo_req_a%0d", i), {31'h0, dmem_req}, 32'h1);
      tick();
    end
    check("tmo_abort_req", {31'h0, dmem_req}, 32'h0);
    check("tmo_err_set",   {31'h0, timeout_err}, 32'h1);
    check("tmo_RegWriteW", {31'h0, RegWriteW}, 32'h0);
    tick();
    check("tmo_err_sticky", {31'h0, timeout_err}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    // ---------------- ready on exactly the 4th ACCESS cycle wins
    set_m(32'h64, 32'h0, 32'h11C, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hA5A5A5A5;
    tick();
    dmem_ready = 1'b0;
    check("tmo_edge_err",       {31'h0, timeout_err}, 32'h0);
    check("tmo_edge_ReadDataW", ReadDataW, 32'hA5A5A5A5);
    check("tmo_edge_RdW",       {27'h0, RdW}, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
